// File: rtl/ad_dac_rate_pkg.sv
// Shared types and state encoding for the DAC rate/valid controller.
package ad_dac_rate_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'b00,
    ST_ARMED = 2'b01,
    ST_RUN   = 2'b10
  } state_t;

endpackage

// File: rtl/ad_dac_trig_sync.sv
// External trigger synchroniser (2 flops) with one history flop for edge detection.
module ad_dac_trig_sync #(
  parameter int unsigned TRIG_RISING = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic trig,
  output logic trig_evt_c
);

  logic [2:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], trig};
    end
  end

  // sync_q[1] is the first metastability-safe sample, sync_q[2] its previous value.
  assign trig_evt_c = (TRIG_RISING != 0) ? (sync_q[1] & ~sync_q[2])
                                         : (~sync_q[1] & sync_q[2]);

endmodule

// File: rtl/ad_dac_rate_ctrl.sv
// DAC sample-rate divider with per-channel valids, sync chaining, external
// trigger arming and a saturating underflow counter.
module ad_dac_rate_ctrl
  import ad_dac_rate_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS = 4,
  parameter int unsigned RATE_WIDTH   = 16,
  parameter int unsigned SYNC_MASTER  = 1,
  parameter int unsigned TRIG_RISING  = 1,
  parameter int unsigned UNF_WIDTH    = 32
) (
  input  logic                    dac_clk,
  input  logic                    dac_rst,
  input  logic                    dac_enable,
  input  logic [RATE_WIDTH-1:0]   dac_datarate,
  input  logic                    dac_sync_local,
  input  logic                    dac_sync_in,
  output logic                    dac_sync_out,
  input  logic                    dac_sync_arm,
  input  logic                    dac_ext_trig,
  input  logic [NUM_CHANNELS-1:0] dac_chan_mask,
  input  logic                    dac_dunf,
  input  logic                    dac_unf_clr,
  output logic                    dac_valid,
  output logic [NUM_CHANNELS-1:0] dac_valid_ch,
  output logic [UNF_WIDTH-1:0]    dac_unf_count,
  output logic [STATE_W-1:0]      dac_state
);

  state_t                state;
  logic [RATE_WIDTH-1:0] cnt;
  logic                  data_sync;
  logic                  sync_sel;
  logic                  trig_evt_c;

  assign sync_sel = (SYNC_MASTER != 0) ? dac_sync_local : dac_sync_in;

  ad_dac_trig_sync #(
    .TRIG_RISING (TRIG_RISING)
  ) u_trig_sync (
    .clk        (dac_clk),
    .rst        (dac_rst),
    .trig       (dac_ext_trig),
    .trig_evt_c (trig_evt_c)
  );

  // Run/armed/idle control; disable overrides everything.
  always_ff @(posedge dac_clk or posedge dac_rst) begin
    if (dac_rst) begin
      state <= ST_RUN;
    end else if (!dac_enable) begin
      state <= ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE:  state <= ST_RUN;
        ST_RUN:   if (dac_sync_arm) state <= ST_ARMED;
        ST_ARMED: if (trig_evt_c) state <= ST_RUN;
        default:  state <= ST_RUN;
      endcase
    end
  end

  // Rate divider: datarate is only sampled on reload, so changes land cleanly.
  always_ff @(posedge dac_clk or posedge dac_rst) begin
    if (dac_rst) begin
      cnt <= '0;
    end else begin
      unique case (state)
        ST_RUN: begin
          if (data_sync || (cnt == '0)) begin
            cnt <= dac_datarate;
          end else begin
            cnt <= cnt - RATE_WIDTH'(1);
          end
        end
        ST_ARMED: begin
          // Zero on trigger release so the first valid follows immediately.
          if (dac_enable && trig_evt_c) begin
            cnt <= '0;
          end else begin
            cnt <= dac_datarate;
          end
        end
        default: cnt <= dac_datarate;
      endcase
    end
  end

  // Sync retiming and valid generation.
  always_ff @(posedge dac_clk or posedge dac_rst) begin
    if (dac_rst) begin
      data_sync    <= 1'b0;
      dac_valid    <= 1'b0;
      dac_valid_ch <= '0;
    end else begin
      data_sync    <= sync_sel;
      dac_valid    <= (state == ST_RUN) && (cnt == '0);
      dac_valid_ch <= dac_valid ? dac_chan_mask : '0;
    end
  end

  // Underflow counter: clear wins, saturates at all-ones.
  always_ff @(posedge dac_clk or posedge dac_rst) begin
    if (dac_rst) begin
      dac_unf_count <= '0;
    end else if (dac_unf_clr) begin
      dac_unf_count <= '0;
    end else if (dac_valid && dac_dunf && (dac_unf_count != '1)) begin
      dac_unf_count <= dac_unf_count + UNF_WIDTH'(1);
    end
  end

  assign dac_sync_out = data_sync;
  assign dac_state    = state;

endmodule

// File: tb/tb_ad_dac_rate_ctrl.sv
// Directed, table-driven bench for ad_dac_rate_ctrl (slave sync, rising trigger, 4-bit underflow count).
module tb_ad_dac_rate_ctrl;

  localparam int unsigned NCH = 4;
  localparam int unsigned RW  = 8;
  localparam int unsigned UW  = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           en = 1'b1;
  logic [RW-1:0]  rate = 8'd3;
  logic           sync_local = 1'b0;
  logic           sync_in = 1'b0;
  logic           arm = 1'b0;
  logic           trig = 1'b0;
  logic [NCH-1:0] mask = 4'h5;
  logic           dunf = 1'b0;
  logic           unf_clr = 1'b0;

  logic           sync_out;
  logic           valid;
  logic [NCH-1:0] valid_ch;
  logic [UW-1:0]  unf_count;
  logic [1:0]     state;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    logic           en;
    logic [RW-1:0]  rate;
    logic [NCH-1:0] mask;
    logic           v;
    logic [NCH-1:0] ch;
    logic [1:0]     st;
  } vec_t;

  vec_t tbl [29];

  ad_dac_rate_ctrl #(
    .NUM_CHANNELS (NCH),
    .RATE_WIDTH   (RW),
    .SYNC_MASTER  (0),
    .TRIG_RISING  (1),
    .UNF_WIDTH    (UW)
  ) dut (
    .dac_clk        (clk),
    .dac_rst        (rst),
    .dac_enable     (en),
    .dac_datarate   (rate),
    .dac_sync_local (sync_local),
    .dac_sync_in    (sync_in),
    .dac_sync_out   (sync_out),
    .dac_sync_arm   (arm),
    .dac_ext_trig   (trig),
    .dac_chan_mask  (mask),
    .dac_dunf       (dunf),
    .dac_unf_clr    (unf_clr),
    .dac_valid      (valid),
    .dac_valid_ch   (valid_ch),
    .dac_unf_count  (unf_count),
    .dac_state      (state)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic e, logic [RW-1:0] r, logic [NCH-1:0] m,
                              logic v, logic [NCH-1:0] c, logic [1:0] s);
    vec_t x;
    x.en = e; x.rate = r; x.mask = m; x.v = v; x.ch = c; x.st = s;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  initial begin
    // Period-4 run, then rate changes that must wait for a reload, mask change, disable/enable.
    tbl[0]  = mk(1'b1, 8'd3, 4'h5, 1'b1, 4'h0, 2'b10);
    tbl[1]  = mk(1'b1, 8'd3, 4'h5, 1'b0, 4'h5, 2'b10);
    tbl[2]  = mk(1'b1, 8'd3, 4'h5, 1'b0, 4'h0, 2'b10);
    tbl[3]  = mk(1'b1, 8'd3, 4'h5, 1'b0, 4'h0, 2'b10);
    tbl[4]  = mk(1'b1, 8'd3, 4'h5, 1'b1, 4'h0, 2'b10);
    tbl[5]  = mk(1'b1, 8'd3, 4'h5, 1'b0, 4'h5, 2'b10);
    tbl[6]  = mk(1'b1, 8'd3, 4'h5, 1'b0, 4'h0, 2'b10);
    tbl[7]  = mk(1'b1, 8'd3, 4'h5, 1'b0, 4'h0, 2'b10);
    tbl[8]  = mk(1'b1, 8'd3, 4'h5, 1'b1, 4'h0, 2'b10);
    tbl[9]  = mk(1'b1, 8'd3, 4'h5, 1'b0, 4'h5, 2'b10);
    tbl[10] = mk(1'b1, 8'd0, 4'h5, 1'b0, 4'h0, 2'b10);
    tbl[11] = mk(1'b1, 8'd0, 4'h5, 1'b0, 4'h0, 2'b10);
    tbl[12] = mk(1'b1, 8'd0, 4'h5, 1'b1, 4'h0, 2'b10);
    tbl[13] = mk(1'b1, 8'd0, 4'h5, 1'b1, 4'h5, 2'b10);
    tbl[14] = mk(1'b1, 8'd0, 4'h5, 1'b1, 4'h5, 2'b10);
    tbl[15] = mk(1'b1, 8'd2, 4'h5, 1'b1, 4'h5, 2'b10);
    tbl[16] = mk(1'b1, 8'd2, 4'h5, 1'b0, 4'h5, 2'b10);
    tbl[17] = mk(1'b1, 8'd2, 4'hA, 1'b0, 4'h0, 2'b10);
    tbl[18] = mk(1'b1, 8'd2, 4'hA, 1'b1, 4'h0, 2'b10);
    tbl[19] = mk(1'b1, 8'd2, 4'hA, 1'b0, 4'hA, 2'b10);
    tbl[20] = mk(1'b1, 8'd2, 4'hA, 1'b0, 4'h0, 2'b10);
    tbl[21] = mk(1'b1, 8'd2, 4'hA, 1'b1, 4'h0, 2'b10);
    tbl[22] = mk(1'b0, 8'd2, 4'hA, 1'b0, 4'hA, 2'b00);
    tbl[23] = mk(1'b0, 8'd2, 4'hA, 1'b0, 4'h0, 2'b00);
    tbl[24] = mk(1'b1, 8'd2, 4'hA, 1'b0, 4'h0, 2'b10);
    tbl[25] = mk(1'b1, 8'd2, 4'hA, 1'b0, 4'h0, 2'b10);
    tbl[26] = mk(1'b1, 8'd2, 4'hA, 1'b0, 4'h0, 2'b10);
    tbl[27] = mk(1'b1, 8'd2, 4'hA, 1'b1, 4'h0, 2'b10);
    tbl[28] = mk(1'b1, 8'd2, 4'hA, 1'b0, 4'hA, 2'b10);

    repeat (2) @(posedge clk);
    #1;
    chk("rst valid", 32'(valid), 32'd0);
    chk("rst valid_ch", 32'(valid_ch), 32'd0);
    chk("rst state", 32'(state), 32'd2);
    chk("rst unf", 32'(unf_count), 32'd0);
    chk("rst sync_out", 32'(sync_out), 32'd0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      en = tbl[i].en; rate = tbl[i].rate; mask = tbl[i].mask;
      tick();
      chk($sformatf("tbl[%0d] valid", i), 32'(valid), 32'(tbl[i].v));
      chk($sformatf("tbl[%0d] valid_ch", i), 32'(valid_ch), 32'(tbl[i].ch));
      chk($sformatf("tbl[%0d] state", i), 32'(state), 32'(tbl[i].st));
      chk($sformatf("tbl[%0d] unf", i), 32'(unf_count), 32'd0);
    end

    // Slave sync: dac_sync_in reloads the countdown; local sync is ignored.
    en = 1'b1; rate = 8'd7; mask = 4'h5;
    pulse_rst();
    for (int c = 1; c <= 20; c++) begin
      sync_in = (c == 3);
      sync_local = (c == 13);
      tick();
      chk($sformatf("sync c%0d valid", c), 32'(valid), 32'((c == 1) || (c == 12) || (c == 20)));
      chk($sformatf("sync c%0d sync_out", c), 32'(sync_out), 32'(c == 3));
    end
    sync_in = 1'b0; sync_local = 1'b0;

    // Arm/trigger: early rising edge ignored in RUN, falling edge ignored when armed.
    rate = 8'd3; trig = 1'b0;
    pulse_rst();
    for (int c = 1; c <= 20; c++) begin
      trig = (c < 7) || (c >= 13);
      arm = (c == 5);
      tick();
      chk($sformatf("trig c%0d valid", c), 32'(valid),
          32'((c == 1) || (c == 5) || (c == 16) || (c == 20)));
      chk($sformatf("trig c%0d valid_ch", c), 32'(valid_ch),
          ((c == 2) || (c == 6) || (c == 17)) ? 32'h5 : 32'h0);
      chk($sformatf("trig c%0d state", c), 32'(state),
          ((c >= 5) && (c <= 14)) ? 32'd1 : 32'd2);
    end
    arm = 1'b0; trig = 1'b0;

    // Disable while armed, with a simultaneous arm request.
    pulse_rst();
    for (int c = 1; c <= 10; c++) begin
      arm = (c == 2) || (c == 4);
      en = (c != 4);
      tick();
      chk($sformatf("en c%0d state", c), 32'(state),
          (c == 4) ? 32'd0 : ((c == 2) || (c == 3)) ? 32'd1 : 32'd2);
      chk($sformatf("en c%0d valid", c), 32'(valid), 32'((c == 1) || (c == 9)));
      chk($sformatf("en c%0d valid_ch", c), 32'(valid_ch),
          ((c == 2) || (c == 10)) ? 32'h5 : 32'h0);
    end
    arm = 1'b0; en = 1'b1;

    // Continuous valid at rate 0, underflow saturation and clear-over-increment.
    rate = 8'd0; dunf = 1'b1;
    pulse_rst();
    for (int c = 1; c <= 22; c++) begin
      unf_clr = (c == 21);
      tick();
      chk($sformatf("unf c%0d valid", c), 32'(valid), 32'd1);
      chk($sformatf("unf c%0d valid_ch", c), 32'(valid_ch), (c >= 2) ? 32'h5 : 32'h0);
      chk($sformatf("unf c%0d count", c), 32'(unf_count),
          (c == 21) ? 32'd0 : (c == 22) ? 32'd1 : (c > 16) ? 32'd15 : 32'(c - 1));
    end
    unf_clr = 1'b0;

    // Arm, then reset mid-cycle: outputs clear at once, ARMED is lost.
    arm = 1'b1;
    tick();
    arm = 1'b0;
    chk("pre-rst state", 32'(state), 32'd1);
    chk("pre-rst valid_ch", 32'(valid_ch), 32'h5);
    #1;
    rst = 1'b1;
    #1;
    chk("async rst valid", 32'(valid), 32'd0);
    chk("async rst valid_ch", 32'(valid_ch), 32'd0);
    chk("async rst state", 32'(state), 32'd2);
    chk("async rst unf", 32'(unf_count), 32'd0);
    #2;
    rst = 1'b0;
    tick();
    chk("post-rst valid", 32'(valid), 32'd1);
    chk("post-rst state", 32'(state), 32'd2);
    tick();
    chk("post-rst valid_ch", 32'(valid_ch), 32'h5);
    chk("post-rst unf", 32'(unf_count), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
